uart_tx_arbiter: RTL

//  Shares the single uart transmitter between NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter_pkg.sv | 29 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The package holds the FSM state encoding, the UART byte width and a small
// constant function used to size the shared cycle counter.

package uart_tx_arbiter_pkg;

    // Width of one byte handed to the UART.
    localparam int UART_DATA_W = 8;

    // Frame sequencing states: grant/capture, load strobe, start gap,
    // wait for completion, inter-frame idle gap.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } arb_state_e;

    // Largest of three integers, used to size the counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker.
// Given the request vector and the index granted last time, returns the first
// requester found searching upward from ptr+1 (wrapping modulo NUM_REQ), so the
// most recently served requester is always considered last.

module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               valid_o,
    output logic [IDW-1:0]     idx_o
);

    // Scan from the farthest candidate down to the nearest one so that the
    // nearest set bit after the pointer is the assignment that sticks.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                idx_o = IDW'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter.
// Shares one UART transmitter between NUM_REQ byte producers. A round-robin
// picker chooses a requester, its byte is captured, then the block drives the
// UART load strobe, raises tx_start after a one-cycle low gap, waits for
// data_transmitted (bounded by a timeout) and enforces an idle gap before the
// next frame. All outputs are registered.

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LOAD_CYCLES    = 14,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDW            = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [UART_DATA_W-1:0]         uart_in_o,
    output logic                           uart_load_o,
    output logic                           uart_tx_start_o,
    input  logic                           uart_data_transmitted_i,
    output logic [IDW-1:0]                 grant_id_o,
    output logic                           busy_o,
    output logic                           frame_done_o,
    output logic                           timeout_err_o
);

    // One counter is shared by LOAD, WAIT and GAP; it is cleared on every
    // state entry and sized so that none of its terminal values can wrap.
    localparam int CNT_W = $clog2(maxOf3(LOAD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    arb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDW-1:0]         rrPtr_q;
    logic [NUM_REQ-1:0]     reqReady_q;
    logic [UART_DATA_W-1:0] uartIn_q;
    logic                   uartLoad_q;
    logic                   txStart_q;
    logic [IDW-1:0]         grantId_q;
    logic                   busy_q;
    logic                   frameDone_q;
    logic                   timeoutErr_q;

    logic                   pickValid;
    logic [IDW-1:0]         pickIdx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (rrPtr_q),
        .valid_o (pickValid),
        .idx_o   (pickIdx)
    );

    // Frame sequencer: grant, load strobe, start edge, completion/timeout, gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rrPtr_q      <= IDW'(NUM_REQ - 1);
            reqReady_q   <= '0;
            uartIn_q     <= '0;
            uartLoad_q   <= 1'b0;
            txStart_q    <= 1'b0;
            grantId_q    <= '0;
            busy_q       <= 1'b0;
            frameDone_q  <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            reqReady_q   <= '0;
            frameDone_q  <= 1'b0;
            timeoutErr_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        uartIn_q   <= req_data_i[int'(pickIdx) * UART_DATA_W +: UART_DATA_W];
                        grantId_q  <= pickIdx;
                        rrPtr_q    <= pickIdx;
                        reqReady_q <= NUM_REQ'(1) << pickIdx;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= LOAD;
                    end
                end

                // The first LOAD cycle lets uart_in settle; load is then
                // raised for exactly LOAD_CYCLES cycles.
                LOAD: begin
                    if (int'(cnt_q) >= LOAD_CYCLES) begin
                        uartLoad_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= START;
                    end else begin
                        uartLoad_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end

                // Both strobes low for one cycle so tx_start always rises on
                // entry to WAIT.
                START: begin
                    txStart_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= WAIT;
                end

                // Completion takes priority over a timeout in the same cycle.
                WAIT: begin
                    if (uart_data_transmitted_i) begin
                        frameDone_q <= 1'b1;
                        txStart_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= GAP;
                    end else if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
                        timeoutErr_q <= 1'b1;
                        txStart_q    <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // The gap only starts counting once the UART has dropped
                // data_transmitted.
                GAP: begin
                    if (uart_data_transmitted_i) begin
                        cnt_q <= '0;
                    end else if (int'(cnt_q) + 1 >= GAP_CYCLES) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = reqReady_q;
    assign uart_in_o       = uartIn_q;
    assign uart_load_o     = uartLoad_q;
    assign uart_tx_start_o = txStart_q;
    assign grant_id_o      = grantId_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = frameDone_q;
    assign timeout_err_o   = timeoutErr_q;

endmodule
